// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter mux.
// Holds the FSM state type and the pointer-advance function.
package arb_pkg;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_t;

  // Advance a round-robin pointer by one, wrapping at m.
  function automatic int rr_next(
    input int ptr,
    input int m
  );
    return (ptr + 1 >= m) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first requester at or after ptr.
// Ports: i_req, i_ptr in; o_pick (one-hot), o_idx (binary), o_any out.
module rr_priority_picker
  import arb_pkg::*;
#(
  parameter int M = 4,
  localparam int PW = $clog2(M)
) (
  input  logic [M-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [M-1:0]  o_pick,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  // Scan distances from high to low so the nearest requester wins last.
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_j    = 0;
    for (int k = M - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= M) w_j = w_j - M;
      if (i_req[w_j]) begin
        o_pick      = '0;
        o_pick[w_j] = 1'b1;
        o_idx       = PW'(w_j);
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_mux.sv
// M-channel registered mux with round-robin arbitration and valid/ready out.
// Ports: i_clk, i_reset_n, i_req, i_lock, i_data_in, i_ready in;
//        o_valid_out, o_data_out, o_grant, o_grant_idx, o_ptr out.
module rr_arbiter_mux
  import arb_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4,
  localparam int PW = $clog2(M)
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic [M-1:0]   i_req,
  input  logic [M-1:0]   i_lock,
  input  logic [M*N-1:0] i_data_in,
  input  logic           i_ready,
  output logic           o_valid_out,
  output logic [N-1:0]   o_data_out,
  output logic [M-1:0]   o_grant,
  output logic [PW-1:0]  o_grant_idx,
  output logic [PW-1:0]  o_ptr
);

  arb_state_t    r_state;
  logic          r_valid;
  logic [N-1:0]  r_data;
  logic [M-1:0]  r_grant;
  logic [PW-1:0] r_gidx;
  logic [PW-1:0] r_ptr;

  logic          w_keep;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_ptr_pick;
  logic [M-1:0]  w_pick;
  logic [PW-1:0] w_idx;
  logic          w_any;
  logic [N-1:0]  w_pick_word;
  logic [N-1:0]  w_hold_word;

  // Grant is one-hot, so masking avoids indexing by a possibly wide idx.
  assign w_keep    = |(i_req & i_lock & r_grant);
  assign w_ptr_nxt = PW'(rr_next(int'(r_gidx), M));

  // In HOLD the picker sees the pointer as it will be after the transfer,
  // so the next owner is chosen in the same cycle with no bubble.
  assign w_ptr_pick = (r_state == HOLD) ? w_ptr_nxt : r_ptr;

  rr_priority_picker #(
    .M (M)
  ) u_pick (
    .i_req  (i_req),
    .i_ptr  (w_ptr_pick),
    .o_pick (w_pick),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_pick_word = i_data_in[int'(w_idx)*N +: N];
  assign w_hold_word = i_data_in[int'(r_gidx)*N +: N];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
            r_data  <= w_pick_word;
            r_grant <= w_pick;
            r_gidx  <= w_idx;
          end
        end
        HOLD: begin
          if (i_ready) begin
            if (w_keep) begin
              r_data <= w_hold_word;
            end else begin
              r_ptr <= w_ptr_nxt;
              if (w_any) begin
                r_data  <= w_pick_word;
                r_grant <= w_pick;
                r_gidx  <= w_idx;
              end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_grant <= '0;
                r_gidx  <= '0;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid_out = r_valid;
  assign o_data_out  = r_data;
  assign o_grant     = r_grant;
  assign o_grant_idx = r_gidx;
  assign o_ptr       = r_ptr;

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Directed scoreboard bench for rr_arbiter_mux (M=4 and M=3 instances).
// Expected words are queued at drive time and checked at delivery.
module tb_rr_arbiter_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  req4, lock4;
  logic [63:0] din4;
  logic        rdy4;
  logic        v4;
  logic [15:0] d4;
  logic [3:0]  g4;
  logic [1:0]  gi4, p4;

  logic [2:0]  req3, lock3;
  logic [47:0] din3;
  logic        rdy3;
  logic        v3;
  logic [15:0] d3;
  logic [2:0]  g3;
  logic [1:0]  gi3, p3;

  rr_arbiter_mux #(.N(16), .M(4)) dut4 (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_req       (req4),
    .i_lock      (lock4),
    .i_data_in   (din4),
    .i_ready     (rdy4),
    .o_valid_out (v4),
    .o_data_out  (d4),
    .o_grant     (g4),
    .o_grant_idx (gi4),
    .o_ptr       (p4)
  );

  rr_arbiter_mux #(.N(16), .M(3)) dut3 (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_req       (req3),
    .i_lock      (lock3),
    .i_data_in   (din3),
    .i_ready     (rdy3),
    .o_valid_out (v3),
    .o_data_out  (d3),
    .o_grant     (g3),
    .o_grant_idx (gi3),
    .o_ptr       (p3)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  g;
    logic [1:0]  gi;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(
    input logic [15:0] d,
    input logic [3:0]  g,
    input logic [1:0]  gi
  );
    exp_t e;
    e.d  = d;
    e.g  = g;
    e.gi = gi;
    sb.push_back(e);
  endtask

  task automatic cmp(
    input string       tag,
    input logic        v,
    input logic [15:0] d,
    input logic [3:0]  g,
    input logic [1:0]  gi,
    input bit          pop
  );
    exp_t e;
    if (sb.size() == 0) begin
      n_tot++;
      $error("FAIL %s: scoreboard empty, observed %0h", tag, d);
    end else begin
      e = pop ? sb.pop_front() : sb[0];
      chk({tag, ".v"}, 32'(v), 32'd1);
      chk({tag, ".d"}, 32'(d), 32'(e.d));
      chk({tag, ".g"}, 32'(g), 32'(e.g));
      chk({tag, ".gi"}, 32'(gi), 32'(e.gi));
    end
  endtask

  task automatic idle4(input string tag, input logic [1:0] ptr);
    chk({tag, ".v"}, 32'(v4), 32'd0);
    chk({tag, ".g"}, 32'(g4), 32'd0);
    chk({tag, ".gi"}, 32'(gi4), 32'd0);
    chk({tag, ".p"}, 32'(p4), 32'(ptr));
  endtask

  initial begin
    rst_n = 1'b0;
    req4 = '0; lock4 = '0; din4 = '0; rdy4 = 1'b0;
    req3 = '0; lock3 = '0; din3 = '0; rdy3 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    idle4("rst", 2'd0);
    chk("rst.d", 32'(d4), 32'h0);

    // Ready while idle does nothing
    rdy4 = 1'b1;
    tick();
    idle4("rdy_idle", 2'd0);

    // Simultaneous requests from Ptr=0
    din4[31:16] = 16'h1111;
    din4[63:48] = 16'h3333;
    req4 = 4'b1010;
    push(16'h1111, 4'b0010, 2'd1);
    push(16'h3333, 4'b1000, 2'd3);
    tick();
    cmp("sim1", v4, d4, g4, gi4, 1'b1);
    chk("sim1.p", 32'(p4), 32'd0);
    req4 = 4'b1000;
    tick();
    cmp("sim2", v4, d4, g4, gi4, 1'b1);
    chk("sim2.p", 32'(p4), 32'd2);
    req4 = 4'b0000;
    tick();
    idle4("sim3", 2'd0);

    // Back-pressure on ch0
    rdy4 = 1'b0;
    din4[15:0] = 16'hA5A5;
    req4 = 4'b0001;
    push(16'hA5A5, 4'b0001, 2'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      req4 = (i % 2 == 1) ? 4'b0000 : 4'b1111;
      din4[15:0] = 16'h1000 + 16'(i);
      tick();
      cmp("bp", v4, d4, g4, gi4, 1'b0);
    end
    req4 = 4'b0000;
    rdy4 = 1'b1;
    cmp("bp_acc", v4, d4, g4, gi4, 1'b1);
    tick();
    idle4("bp_done", 2'd1);

    // Reset to bring Ptr back to 0 for the burst test
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle4("rst2", 2'd0);

    // Burst lock on ch0, then release to ch1
    lock4 = 4'b0001;
    req4 = 4'b0011;
    din4[15:0]  = 16'h0010;
    din4[31:16] = 16'h1234;
    push(16'h0010, 4'b0001, 2'd0);
    tick();
    cmp("lk0", v4, d4, g4, gi4, 1'b1);
    chk("lk0.p", 32'(p4), 32'd0);
    din4[15:0] = 16'h0011;
    push(16'h0011, 4'b0001, 2'd0);
    tick();
    cmp("lk1", v4, d4, g4, gi4, 1'b1);
    chk("lk1.p", 32'(p4), 32'd0);
    din4[15:0] = 16'h0012;
    push(16'h0012, 4'b0001, 2'd0);
    tick();
    cmp("lk2", v4, d4, g4, gi4, 1'b1);
    chk("lk2.p", 32'(p4), 32'd0);
    lock4 = 4'b0000;
    push(16'h1234, 4'b0010, 2'd1);
    tick();
    cmp("lk3", v4, d4, g4, gi4, 1'b1);
    chk("lk3.p", 32'(p4), 32'd1);
    req4 = 4'b0000;
    tick();
    idle4("lk_done", 2'd2);

    // Reset during HOLD drops the word
    rdy4 = 1'b0;
    req4 = 4'b0100;
    din4[47:32] = 16'hBEEF;
    push(16'hBEEF, 4'b0100, 2'd2);
    tick();
    cmp("rh", v4, d4, g4, gi4, 1'b1);
    chk("rh.p", 32'(p4), 32'd2);
    rst_n = 1'b0;
    req4 = 4'b0000;
    tick();
    rst_n = 1'b1;
    idle4("rh_rst", 2'd0);
    chk("rh_rst.d", 32'(d4), 32'h0);

    // Requester drops Req right after capture
    req4 = 4'b1000;
    din4[63:48] = 16'h7E57;
    push(16'h7E57, 4'b1000, 2'd3);
    tick();
    req4 = 4'b0000;
    din4[63:48] = 16'h0000;
    tick();
    tick();
    cmp("dac_hold", v4, d4, g4, gi4, 1'b0);
    rdy4 = 1'b1;
    cmp("dac_acc", v4, d4, g4, gi4, 1'b1);
    tick();
    idle4("dac_done", 2'd0);

    // M=3: move Ptr to 2 via ch1, then wrap ch2, ch0, ch1
    rdy3 = 1'b1;
    req3 = 3'b010;
    din3[31:16] = 16'h0101;
    push(16'h0101, 4'b0010, 2'd1);
    tick();
    cmp("m3a", v3, d3, {1'b0, g3}, gi3, 1'b1);
    req3 = 3'b000;
    tick();
    chk("m3a.v", 32'(v3), 32'd0);
    chk("m3a.p", 32'(p3), 32'd2);
    din3 = {16'h0A02, 16'h0A01, 16'h0A00};
    req3 = 3'b111;
    push(16'h0A02, 4'b0100, 2'd2);
    push(16'h0A00, 4'b0001, 2'd0);
    push(16'h0A01, 4'b0010, 2'd1);
    tick();
    cmp("m3b", v3, d3, {1'b0, g3}, gi3, 1'b1);
    chk("m3b.p", 32'(p3), 32'd2);
    req3 = 3'b011;
    tick();
    cmp("m3c", v3, d3, {1'b0, g3}, gi3, 1'b1);
    chk("m3c.p", 32'(p3), 32'd0);
    req3 = 3'b010;
    tick();
    cmp("m3d", v3, d3, {1'b0, g3}, gi3, 1'b1);
    chk("m3d.p", 32'(p3), 32'd1);
    req3 = 3'b000;
    tick();
    chk("m3e.v", 32'(v3), 32'd0);
    chk("m3e.g", 32'(g3), 32'd0);
    chk("m3e.p", 32'(p3), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
